key_conditioner: RTL and testbench

Parametrised multi-channel push-button conditioner for the game's user controls. Each channel passes a raw key line through a two-flop synchroniser and a debounce counter, then produces a debounced level plus single-cycle press and release strobes. An optional auto-repeat mode re-issues press strobes while a key is held. It sits between the board keys and the game control FSM, and supersedes the single-bit registered key input.

---
 rtl/key_conditioner.sv | 161 ++++++++++++++++
 tb/tb_key_conditioner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: multi-channel push-button conditioner.
// Each channel runs a two-flop synchroniser and a debounce counter, and
// produces a debounced level plus single-cycle press/release strobes.
// Optional auto-repeat of press strobes while a key is held is compiled in
// when the macro KEY_CONDITIONER_REPEAT_EN is defined.
module key_conditioner #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] key_raw,
  output logic [N-1:0] key_level,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic         any_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the counters cannot represent.
  if (N < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
    $error("key_conditioner: illegal parameter values");
  end

`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;
`endif

  // Next-cycle press strobes of all channels, shared by any_press.
  logic [N-1:0] press_nxt;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_nxt;
    logic             rise;
    logic             fall;
    logic             press_r;
    logic             release_r;

    // Debounced level accepts the synchronised value after a full stable count.
    always_comb begin
      level_nxt = level;
      if ((sync_p1 != level) && (cnt == CNT_LAST)) level_nxt = sync_p1;
      rise = level_nxt & ~level;
      fall = ~level_nxt & level;
    end

`ifdef KEY_CONDITIONER_REPEAT_EN
    rpt_state_t       state;
    rpt_state_t       state_nxt;
    logic [RPT_W-1:0] rcnt;
    logic [RPT_W-1:0] rcnt_nxt;
    logic             rpt_fire;

    // Repeat FSM next state: arm on the initial press, disarm when level falls.
    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rpt_fire  = 1'b0;
      case (state)
        RPT_IDLE: begin
          if (rise) begin
            state_nxt = RPT_DELAY;
            rcnt_nxt  = '0;
          end
        end
        RPT_DELAY: begin
          if (fall) begin
            state_nxt = RPT_IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == DLY_LAST) begin
            rpt_fire  = 1'b1;
            state_nxt = RPT_REPEAT;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (fall) begin
            state_nxt = RPT_IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == PER_LAST) begin
            rpt_fire = 1'b1;
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = RPT_IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end

    // Repeat FSM state and interval counter.
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= RPT_IDLE;
        rcnt  <= '0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
      end
    end

    assign press_nxt[i] = rise | rpt_fire;
`else
    assign press_nxt[i] = rise;
`endif

    // Synchroniser, debounce counter, level and strobe registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_p0   <= 1'b0;
        sync_p1   <= 1'b0;
        cnt       <= '0;
        level     <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        sync_p0   <= key_raw[i];
        sync_p1   <= sync_p0;
        level     <= level_nxt;
        press_r   <= press_nxt[i];
        release_r <= fall;
        if (sync_p1 == level)     cnt <= '0;
        else if (cnt == CNT_LAST) cnt <= '0;
        else                      cnt <= cnt + 1'b1;
      end
    end

    assign key_level[i]   = level;
    assign key_press[i]   = press_r;
    assign key_release[i] = release_r;
  end

  // Registered OR of the next press strobes so it aligns with key_press.
  always_ff @(posedge clk) begin
    if (reset) any_press <= 1'b0;
    else       any_press <= |press_nxt;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed testbench for key_conditioner (N=4, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=4). Expected repeat behaviour follows
// KEY_CONDITIONER_REPEAT_EN.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_raw;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       any_press;

  int checks = 0;
  int errors = 0;

  key_conditioner #(
    .N(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Concatenation of all outputs: {level, press, release, any}.
  function automatic logic [12:0] outs();
    return {key_level, key_press, key_release, any_press};
  endfunction

  logic [63:0] mask;
  logic [63:0] exp_mask;
  logic        rel_seen;
  logic        rel_any;

  initial begin
    reset   = 1'b1;
    key_raw = 4'hF;

    // Reset held for 3 cycles with all keys pressed.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset_outs", 64'(outs()), 64'd0);
    end
    reset = 1'b0;
    repeat (5) tick();
    check("post_reset_e5_level", 64'(key_level), 64'h0);
    tick();
    check("post_reset_e6", 64'(outs()), 64'({4'hF, 4'hF, 4'h0, 1'b1}));
    tick();
    check("post_reset_e7", 64'(outs()), 64'({4'hF, 4'h0, 4'h0, 1'b0}));

    // Release everything.
    key_raw = 4'h0;
    repeat (5) tick();
    check("all_rel_e5", 64'(key_release), 64'h0);
    tick();
    check("all_rel_e6", 64'(outs()), 64'({4'h0, 4'h0, 4'hF, 1'b0}));
    tick();
    check("all_rel_e7", 64'(key_release), 64'h0);

    // Clean press/release on channel 0.
    key_raw = 4'b0001;
    repeat (5) tick();
    check("ch0_press_e5", 64'(key_level), 64'h0);
    tick();
    check("ch0_press_e6", 64'(outs()), 64'({4'b0001, 4'b0001, 4'h0, 1'b1}));
    tick();
    check("ch0_press_e7", 64'(outs()), 64'({4'b0001, 4'h0, 4'h0, 1'b0}));
    repeat (13) tick();
    key_raw = 4'b0000;
    repeat (5) tick();
    check("ch0_rel_e5", 64'(outs()), 64'({4'b0001, 4'h0, 4'h0, 1'b0}));
    tick();
    check("ch0_rel_e6", 64'(outs()), 64'({4'h0, 4'h0, 4'b0001, 1'b0}));
    tick();
    check("ch0_rel_e7", 64'(outs()), 64'd0);

    // Bounce on channel 1: 3 high, 1 low, then held.
    key_raw = 4'b0010;
    repeat (3) tick();
    key_raw = 4'b0000;
    tick();
    key_raw = 4'b0010;
    repeat (5) tick();
    check("ch1_bounce_e5", 64'(outs()), 64'd0);
    tick();
    check("ch1_bounce_e6", 64'(outs()), 64'({4'b0010, 4'b0010, 4'h0, 1'b1}));
    tick();
    check("ch1_bounce_e7", 64'(key_press), 64'h0);
    key_raw = 4'b0000;
    repeat (6) tick();
    check("ch1_rel", 64'(key_release), 64'({4'b0010}));
    tick();

    // Repeat on channel 2; raw released so level falls at t+30.
    key_raw  = 4'b0100;
    mask     = '0;
    rel_seen = 1'b0;
    repeat (5) tick();
    for (int k = 0; k <= 40; k++) begin
      tick();
      mask[k] = key_press[2];
      if (k == 30) rel_seen = key_release[2];
      if (k == 24) key_raw = 4'b0000;
    end
`ifdef KEY_CONDITIONER_REPEAT_EN
    exp_mask = (64'd1 << 0) | (64'd1 << 8) | (64'd1 << 12) | (64'd1 << 16) |
               (64'd1 << 20) | (64'd1 << 24) | (64'd1 << 28);
`else
    exp_mask = 64'd1;
`endif
    check("ch2_repeat_mask", mask, exp_mask);
    check("ch2_release_t30", 64'(rel_seen), 64'd1);

    // Reset mid-hold on channel 3.
    key_raw = 4'b1000;
    repeat (6) tick();
    check("ch3_press", 64'(outs()), 64'({4'b1000, 4'b1000, 4'h0, 1'b1}));
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("ch3_reset_outs", 64'(outs()), 64'd0);
    reset   = 1'b0;
    rel_any = 1'b0;
    repeat (5) begin
      tick();
      rel_any = rel_any | (|key_release);
    end
    check("ch3_after_reset_level", 64'(key_level), 64'h0);
    tick();
    rel_any = rel_any | (|key_release);
    check("ch3_no_release", 64'(rel_any), 64'd0);
    check("ch3_repress_e6", 64'(outs()), 64'({4'b1000, 4'b1000, 4'h0, 1'b1}));
    key_raw = 4'b0000;
    repeat (7) tick();

    // Simultaneous press on channels 0 and 1.
    key_raw = 4'b0011;
    repeat (6) tick();
    check("simul_e6", 64'(outs()), 64'({4'b0011, 4'b0011, 4'h0, 1'b1}));
    tick();
    check("simul_e7", 64'(outs()), 64'({4'b0011, 4'h0, 4'h0, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
